dup_arb: RTL and testbench

DUP_ARB -- requirements
Module: dup_arb

---
 rtl/dup_pkg.sv | 18 +
 rtl/dup_rr_pick.sv | 26 ++
 rtl/dup_arb.sv | 107 ++++++++++
 tb/tb_dup_arb.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dup_pkg.sv
// Shared types and constants for the duplicating round-robin arbiter.
package dup_pkg;

  localparam int NREQ = 4;
  localparam logic [7:0] X_RST = 8'h0F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Upper nibble carries w, lower nibble its complement.
  function automatic logic [7:0] pattern(input logic w);
    return {{4{w}}, {4{~w}}};
  endfunction

endpackage

// File: rtl/dup_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping mod 4.
module dup_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] sel,
  output logic       any_req
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    sel     = '0;
    idx     = '0;
    found   = 1'b0;
    any_req = |req;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dup_arb.sv
// Round-robin arbiter that samples the granted requester's bit and presents it duplicated/complemented on x.
// req at t -> gnt at t+1 -> vld at t+2; x/src/vld hold until vld && rdy, then re-arbitrate with no idle bubble.
module dup_arb #(
  parameter int NREQ = dup_pkg::NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] a,
  input  logic            rdy,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      x,
  output logic            vld,
  output logic [1:0]      src,
  output logic            busy
);

  import dup_pkg::*;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_d;
  logic [7:0]      x_d;
  logic            vld_d;
  logic [1:0]      src_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            w_q, w_d;
  logic [1:0]      pick_ptr;
  logic [1:0]      sel;
  logic            any_req;

  // On a handshake the pointer update and the next pick happen in the same cycle,
  // so the picker must already see the advanced pointer.
  assign pick_ptr = (state_q == OUT) ? src_q_next_ptr() : ptr_q;

  function automatic logic [1:0] src_q_next_ptr();
    return src + 2'd1;
  endfunction

  dup_rr_pick u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .sel     (sel),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    x_d     = x;
    vld_d   = vld;
    src_d   = src;
    ptr_d   = ptr_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d[sel] = 1'b1;
          src_d      = sel;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        w_d     = a[src];
        x_d     = pattern(a[src]);
        vld_d   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (rdy) begin
          vld_d = 1'b0;
          ptr_d = pick_ptr;
          if (any_req) begin
            gnt_d[sel] = 1'b1;
            src_d      = sel;
            state_d    = GRANT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      vld     <= 1'b0;
      w_q     <= 1'b0;
      x       <= X_RST;
      src     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      vld     <= vld_d;
      w_q     <= w_d;
      x       <= x_d;
      src     <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dup_arb.sv
// Scoreboard bench for dup_arb: a transaction-level model predicts each output word, a monitor checks it.
module tb_dup_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] a;
  logic       rdy;
  logic [3:0] gnt;
  logic [7:0] x;
  logic       vld;
  logic [1:0] src;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int n_hs  = 0;

  typedef struct {
    logic [1:0] src;
    logic [7:0] x;
  } exp_t;

  exp_t exp_q[$];

  // Model phase: 0 = nothing owed, 1 = grant visible, 2 = word on offer.
  int         m_ph    = 0;
  logic [1:0] m_sel   = '0;
  logic [1:0] m_ptr   = '0;
  logic [7:0] m_lastx = 8'h0F;

  always #5 clk = ~clk;

  dup_arb #(.NREQ(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a    (a),
    .rdy  (rdy),
    .gnt  (gnt),
    .x    (x),
    .vld  (vld),
    .src  (src),
    .busy (busy)
  );

  function automatic logic [1:0] rr(input logic [3:0] r, input logic [1:0] p);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (int'(p) + k) % 4;
      if (r[j]) return 2'(j);
    end
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] aa,
                      input logic rd, input int n);
    rst = r; req = rq; a = aa; rdy = rd;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model, advanced with the same inputs the DUT samples.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ph = 0; m_ptr = '0; m_sel = '0; m_lastx = 8'h0F;
        exp_q.delete();
      end else begin
        case (m_ph)
          0: if (req != 4'b0) begin
               m_sel = rr(req, m_ptr);
               m_ph  = 1;
             end
          1: begin
               e.src   = m_sel;
               e.x     = a[m_sel] ? 8'hF0 : 8'h0F;
               exp_q.push_back(e);
               m_lastx = e.x;
               m_ph    = 2;
             end
          default: if (rdy) begin
               m_ptr = m_sel + 2'd1;
               if (req != 4'b0) begin
                 m_sel = rr(req, m_ptr);
                 m_ph  = 1;
               end else begin
                 m_ph = 0;
               end
             end
        endcase
      end
    end
  end

  // Monitor: checks control outputs every cycle and pops the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      chk("gnt", 32'(gnt), (m_ph == 1) ? 32'(4'b0001 << m_sel) : 32'h0);
      chk("vld", 32'(vld), 32'(m_ph == 2));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      if (vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", 32'(vld), 32'h0);
        end else begin
          chk("x", 32'(x), 32'(exp_q[0].x));
          chk("src", 32'(src), 32'(exp_q[0].src));
          if (rdy) begin
            void'(exp_q.pop_front());
            n_hs++;
          end
        end
      end else begin
        chk("x_hold", 32'(x), 32'(m_lastx));
      end
    end
  end

  initial begin
    // Reset then quiet.
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 2);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 3);
    // Single request from requester 2 with a[2] = 1.
    step(1'b0, 4'b0100, 4'b0100, 1'b1, 1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 4);
    // Backpressure on requester 0 with a[0] = 0.
    step(1'b0, 4'b0001, 4'b0000, 1'b0, 1);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 6);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 3);
    // All requesting: rotation and wrap.
    for (int i = 0; i < 20; i++)
      step(1'b0, 4'b1111, 4'($urandom_range(0, 15)), 1'b1, 1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 3);
    // Reset while requester 3 is on offer, then 1 must win from ptr 0.
    step(1'b0, 4'b1000, 4'b1000, 1'b0, 1);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 3);
    step(1'b1, 4'b0000, 4'b0000, 1'b0, 1);
    step(1'b0, 4'b1010, 4'b0010, 1'b1, 1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 4);
    // Request dropped after one cycle still completes.
    step(1'b0, 4'b0010, 4'b0010, 1'b1, 1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 5);
    // Random traffic with occasional reset and stalls.
    for (int i = 0; i < 400; i++)
      step(($urandom % 60) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom % 4) != 0, 1);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 5);
    chk("handshake_count_min", 32'(n_hs >= 20), 32'h1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
